note_detector: RTL and testbench



---
 rtl/note_detector.sv | 126 ++++++++++++
 tb/tb_note_detector.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_detector.sv
// Per-frame peak energy per note -> on/off hysteresis -> consecutive-frame debounce -> NDATA.
// Define NOTE_DETECT_PEAK_EN for single-peak mode; by default notes are evaluated independently.
module note_detector #(
    parameter int NOTES       = 37,
    parameter int EW          = 16,
    parameter int ON_THRESH   = 1000,
    parameter int OFF_THRESH  = 600,
    parameter int HOLD_FRAMES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [5:0]       in_note,
    input  logic [EW-1:0]    in_energy,
    input  logic             in_last,
    output logic [NOTES-1:0] NDATA,
    output logic             ndata_valid,
    output logic [15:0]      frame_count,
    output logic             range_err
);
    localparam int            CW       = $clog2(HOLD_FRAMES) + 1;
    localparam logic [6:0]    NOTES_L  = 7'(NOTES);
    localparam logic [EW-1:0] ON_L     = EW'(ON_THRESH);
    localparam logic [EW-1:0] OFF_L    = EW'(OFF_THRESH);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_FRAMES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    function automatic logic [EW-1:0] peak_max(input logic [EW-1:0] a, input logic [EW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // A held note only lets go below OFF; an idle note needs ON to start.
    function automatic logic hyst(input logic held, input logic [EW-1:0] p);
        return held ? (p >= OFF_L) : (p >= ON_L);
    endfunction

    logic [EW-1:0]    peak_p0 [NOTES];
    logic [EW-1:0]    merged  [NOTES];
    logic [CW-1:0]    cnt_p1  [NOTES];
    logic [NOTES-1:0] ndata_p1;
    logic [NOTES-1:0] cand;
    logic             vld_p1;
    logic             beat_ok;

    assign beat_ok = in_valid && ({1'b0, in_note} < NOTES_L);

    // Stage 0: running peaks with the current beat folded in combinationally
    always_comb begin
        for (int i = 0; i < NOTES; i++) begin
            merged[i] = peak_p0[i];
            if (beat_ok && (in_note == 6'(i)))
                merged[i] = peak_max(peak_p0[i], in_energy);
        end
    end

`ifdef NOTE_DETECT_PEAK_EN
    logic [5:0]    win_idx;
    logic [EW-1:0] win_val;

    // Strict '>' while scanning upward keeps the lowest index on ties.
    always_comb begin
        win_idx = '0;
        win_val = merged[0];
        for (int i = 1; i < NOTES; i++) begin
            if (merged[i] > win_val) begin
                win_idx = 6'(i);
                win_val = merged[i];
            end
        end
    end

    always_comb begin
        cand = '0;
        for (int i = 0; i < NOTES; i++)
            cand[i] = hyst(ndata_p1[i], (win_idx == 6'(i)) ? merged[i] : '0);
    end
`else
    always_comb begin
        cand = '0;
        for (int i = 0; i < NOTES; i++)
            cand[i] = hyst(ndata_p1[i], merged[i]);
    end
`endif

    // Stage 1: debounce and publish at frame close
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NOTES; i++) begin
                peak_p0[i] <= '0;
                cnt_p1[i]  <= '0;
            end
            ndata_p1    <= '0;
            vld_p1      <= 1'b0;
            frame_count <= '0;
            range_err   <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (enable) begin
                if (in_valid && !beat_ok)
                    range_err <= 1'b1;
                if (in_last) begin
                    for (int i = 0; i < NOTES; i++) begin
                        peak_p0[i] <= '0;
                        if (cand[i] == ndata_p1[i]) begin
                            cnt_p1[i] <= '0;
                        end else if (cnt_p1[i] == CNT_LAST) begin
                            ndata_p1[i] <= cand[i];
                            cnt_p1[i]   <= '0;
                        end else begin
                            cnt_p1[i] <= cnt_p1[i] + CNT_ONE;
                        end
                    end
                    frame_count <= frame_count + 16'd1;
                    vld_p1      <= 1'b1;
                end else begin
                    for (int i = 0; i < NOTES; i++)
                        peak_p0[i] <= merged[i];
                end
            end
        end
    end

    assign NDATA       = ndata_p1;
    assign ndata_valid = vld_p1;
endmodule

// File: tb/tb_note_detector.sv
// Self-checking bench for note_detector: hand-derived vector table, corner sequences, random vs model.
module tb_note_detector;
    localparam int NOTES = 37, EW = 16, ON_THRESH = 1000, OFF_THRESH = 600, HOLD_FRAMES = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             in_valid = 1'b0;
    logic [5:0]       in_note = '0;
    logic [EW-1:0]    in_energy = '0;
    logic             in_last = 1'b0;
    logic [NOTES-1:0] NDATA;
    logic             ndata_valid;
    logic [15:0]      frame_count;
    logic             range_err;

    note_detector #(
        .NOTES(NOTES), .EW(EW), .ON_THRESH(ON_THRESH),
        .OFF_THRESH(OFF_THRESH), .HOLD_FRAMES(HOLD_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_note(in_note), .in_energy(in_energy), .in_last(in_last),
        .NDATA(NDATA), .ndata_valid(ndata_valid), .frame_count(frame_count),
        .range_err(range_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: frame peaks, held notes, length of the current disagreeing run
    int               m_pk  [NOTES];
    int               m_run [NOTES];
    logic [NOTES-1:0] m_nd;
    int               m_fc;
    bit               m_rerr;
    bit               m_vld;

    typedef struct {
        bit en; bit v; int note; int energy; bit last;
        logic [NOTES-1:0] nd; bit vld; int fc; bit rerr;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NOTES; i++) begin
            m_pk[i]  = 0;
            m_run[i] = 0;
        end
        m_nd = '0; m_fc = 0; m_rerr = 1'b0; m_vld = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit v, input int n, input int e, input bit l);
        int p [NOTES];
        int win;
        m_vld = 1'b0;
        if (!en) return;
        if (v && n >= NOTES) m_rerr = 1'b1;
        if (!l) begin
            if (v && n < NOTES && e > m_pk[n]) m_pk[n] = e;
            return;
        end
        for (int i = 0; i < NOTES; i++) p[i] = m_pk[i];
        if (v && n < NOTES && e > p[n]) p[n] = e;
`ifdef NOTE_DETECT_PEAK_EN
        win = 0;
        for (int i = 1; i < NOTES; i++) if (p[i] > p[win]) win = i;
        for (int i = 0; i < NOTES; i++) if (i != win) p[i] = 0;
`else
        win = 0;
`endif
        for (int i = 0; i < NOTES; i++) begin
            bit want;
            want = m_nd[i] ? (p[i] >= OFF_THRESH) : (p[i] >= ON_THRESH);
            if (want == m_nd[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] >= HOLD_FRAMES) begin
                    m_nd[i]  = want;
                    m_run[i] = 0;
                end
            end
            m_pk[i] = 0;
        end
        m_fc  = (m_fc + 1) % 65536;
        m_vld = 1'b1;
    endtask

    task automatic step(input bit en, input bit v, input int n, input int e, input bit l);
        enable = en; in_valid = v; in_note = n[5:0]; in_energy = e[15:0]; in_last = l;
        @(posedge clk); #1;
        model_step(en, v, n, e, l);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_ndata"}, 64'(NDATA), 64'(m_nd));
        chk({tag, "_vld"}, 64'(ndata_valid), 64'(m_vld));
        chk({tag, "_fc"}, 64'(frame_count), 64'(m_fc));
        chk({tag, "_rerr"}, 64'(range_err), 64'(m_rerr));
    endtask

    task automatic do_reset();
        enable = 0; in_valid = 0; in_last = 0; in_note = '0; in_energy = '0;
        #2 reset = 1'b1;
        #1;
        chk("reset_ndata", 64'(NDATA), 64'd0);
        chk("reset_vld", 64'(ndata_valid), 64'd0);
        chk("reset_fc", 64'(frame_count), 64'd0);
        chk("reset_rerr", 64'(range_err), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    function automatic vec_t mk(bit en, bit v, int n, int e, bit l, int ndb, bit vld, int fc, bit re);
        vec_t r;
        r.en = en; r.v = v; r.note = n; r.energy = e; r.last = l;
        r.nd = '0;
        if (ndb >= 0) r.nd[ndb] = 1'b1;
        r.vld = vld; r.fc = fc; r.rerr = re;
        return r;
    endfunction

    function automatic logic [NOTES-1:0] bits2(int a, int b);
        logic [NOTES-1:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            en v  note energy last  nd  vld fc rerr
        tbl.push_back(mk(1,1, 5,1200,0, -1,0, 0,0)); tbl.push_back(mk(1,0,0,0,1, -1,1, 1,0));
        tbl.push_back(mk(1,1, 5,1200,0, -1,0, 1,0)); tbl.push_back(mk(1,0,0,0,1,  5,1, 2,0));
        tbl.push_back(mk(1,1, 5,1200,0,  5,0, 2,0)); tbl.push_back(mk(1,0,0,0,1,  5,1, 3,0));
        tbl.push_back(mk(1,1, 5, 700,0,  5,0, 3,0)); tbl.push_back(mk(1,0,0,0,1,  5,1, 4,0));
        tbl.push_back(mk(1,1, 5, 700,0,  5,0, 4,0)); tbl.push_back(mk(1,0,0,0,1,  5,1, 5,0));
        tbl.push_back(mk(1,1, 5, 500,0,  5,0, 5,0)); tbl.push_back(mk(1,0,0,0,1,  5,1, 6,0));
        tbl.push_back(mk(1,1, 5, 500,0,  5,0, 6,0)); tbl.push_back(mk(1,0,0,0,1, -1,1, 7,0));
        tbl.push_back(mk(1,1, 9,1200,0, -1,0, 7,0)); tbl.push_back(mk(1,0,0,0,1, -1,1, 8,0));
        tbl.push_back(mk(1,0, 0,   0,1, -1,1, 9,0));
        tbl.push_back(mk(1,1, 9,1200,0, -1,0, 9,0)); tbl.push_back(mk(1,0,0,0,1, -1,1,10,0));
        tbl.push_back(mk(1,0, 0,   0,1, -1,1,11,0));
        tbl.push_back(mk(1,1, 3,1500,1, -1,1,12,0)); tbl.push_back(mk(1,1,3,1500,1, 3,1,13,0));
        tbl.push_back(mk(1,1, 4,1500,0,  3,0,13,0)); tbl.push_back(mk(1,0,0,0,1,    3,1,14,0));
        tbl.push_back(mk(1,1, 4,1500,0,  3,0,14,0)); tbl.push_back(mk(1,0,0,0,1,    4,1,15,0));
        tbl.push_back(mk(1,1,20,1500,1,  4,1,16,0)); tbl.push_back(mk(1,0,0,0,0,    4,0,16,0));
        tbl.push_back(mk(1,0, 0,   0,1, -1,1,17,0)); tbl.push_back(mk(1,0,0,0,1,   -1,1,18,0));
        tbl.push_back(mk(1,1,40,5000,0, -1,0,18,1)); tbl.push_back(mk(1,1,8,1500,0, -1,0,18,1));
        tbl.push_back(mk(0,1, 6,2000,1, -1,0,18,1)); tbl.push_back(mk(0,0,0,0,1,   -1,0,18,1));
        tbl.push_back(mk(1,0, 0,   0,1, -1,1,19,1)); tbl.push_back(mk(1,1,8,1500,0, -1,0,19,1));
        tbl.push_back(mk(0,1, 8,  10,0, -1,0,19,1)); tbl.push_back(mk(1,0,0,0,1,    8,1,20,1));
        tbl.push_back(mk(1,1,10,1000,1,  8,1,21,1)); tbl.push_back(mk(1,1,10,1000,1,10,1,22,1));
        tbl.push_back(mk(1,1,10, 600,1, 10,1,23,1)); tbl.push_back(mk(1,1,10, 600,1,10,1,24,1));
        tbl.push_back(mk(1,1,10, 599,1, 10,1,25,1)); tbl.push_back(mk(1,1,10, 599,1,-1,1,26,1));
        tbl.push_back(mk(1,1,11, 999,1, -1,1,27,1)); tbl.push_back(mk(1,1,11, 999,1,-1,1,28,1));
        tbl.push_back(mk(1,1,12, 300,0, -1,0,28,1)); tbl.push_back(mk(1,1,12,1100,0,-1,0,28,1));
        tbl.push_back(mk(1,1,12, 200,1, -1,1,29,1)); tbl.push_back(mk(1,1,12, 300,0,-1,0,29,1));
        tbl.push_back(mk(1,1,12,1100,0, -1,0,29,1)); tbl.push_back(mk(1,1,12, 200,1,12,1,30,1));

        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].v, tbl[i].note, tbl[i].energy, tbl[i].last);
            chk($sformatf("row%0d_ndata", i), 64'(NDATA), 64'(tbl[i].nd));
            chk($sformatf("row%0d_vld", i), 64'(ndata_valid), 64'(tbl[i].vld));
            chk($sformatf("row%0d_fc", i), 64'(frame_count), 64'(tbl[i].fc));
            chk($sformatf("row%0d_rerr", i), 64'(range_err), 64'(tbl[i].rerr));
        end

        // Reset mid-frame must discard the partial peak of note 5
        do_reset();
        step(1, 1, 5, 1500, 0);
        do_reset();
        step(1, 0, 0, 0, 1);
        chk("rstmid_close1_ndata", 64'(NDATA), 64'd0);
        chk("rstmid_close1_fc", 64'(frame_count), 64'd1);
        step(1, 1, 5, 1500, 0);
        step(1, 0, 0, 0, 1);
        chk("rstmid_close2_ndata", 64'(NDATA), 64'd0);
        step(1, 1, 5, 1500, 0);
        step(1, 0, 0, 0, 1);
        chk("rstmid_close3_ndata", 64'(NDATA), 64'(bits2(5, -1)));
        chk("rstmid_close3_fc", 64'(frame_count), 64'd3);

        // Chord: 2@1100 + 7@1300, then a 2/7 tie at 1300
        do_reset();
        for (int f = 0; f < 2; f++) begin
            step(1, 1, 2, 1100, 0);
            step(1, 1, 7, 1300, 1);
        end
`ifdef NOTE_DETECT_PEAK_EN
        chk("chord_ndata", 64'(NDATA), 64'(bits2(7, -1)));
`else
        chk("chord_ndata", 64'(NDATA), 64'(bits2(2, 7)));
`endif
        for (int f = 0; f < 2; f++) begin
            step(1, 1, 2, 1300, 0);
            step(1, 1, 7, 1300, 1);
        end
`ifdef NOTE_DETECT_PEAK_EN
        chk("tie_ndata", 64'(NDATA), 64'(bits2(2, -1)));
`else
        chk("tie_ndata", 64'(NDATA), 64'(bits2(2, 7)));
`endif
        chk("tie_fc", 64'(frame_count), 64'd4);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            bit en, v, l;
            int n, e, sel;
            en  = ($urandom_range(0, 9) != 0);
            v   = ($urandom_range(0, 3) != 0);
            n   = ($urandom_range(0, 30) == 0) ? int'($urandom_range(37, 63)) : int'($urandom_range(0, 5));
            sel = $urandom_range(0, 5);
            case (sel)
                0: e = $urandom_range(0, 400);
                1: e = 599;
                2: e = 600;
                3: e = 999;
                4: e = 1000;
                default: e = $urandom_range(1000, 65535);
            endcase
            l = ($urandom_range(0, 3) == 0);
            step(en, v, n, e, l);
            chk_model($sformatf("rnd%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
